// File: rtl/pipe_ctrl_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_ctrl_unit                                             |
// | Description : Control unit for a 5-stage RISC-V pipeline. It decodes the |
// |               opcode in ID and carries the control bits and register     |
// |               indices through ID/EX, EX/MEM and MEM/WB. It also          |
// |               generates the load-use stall, the taken-branch flush and   |
// |               the EX operand-forward selects. The datapath holds the     |
// |               data; this block holds all control state.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, reset            clock, synchronous active-high reset             |
// |   opcode_id             opcode of the instruction in ID                  |
// |   rs1_id/rs2_id/rd_id   register fields in ID                            |
// |   alu_zero_ex           ALU zero flag of the instruction in EX           |
// |   ex_*                  EX-stage controls and source indices             |
// |   mem_*                 MEM-stage controls and destination index         |
// |   wb_*                  WB-stage controls and destination index          |
// |   fwd_a/fwd_b           00 regfile, 10 EX/MEM, 01 MEM/WB                 |
// |   pc_write/ifid_write   PC and IF/ID load enables                        |
// |   ifid_flush            clear IF/ID on this edge                         |
// |   branch_taken          select branch target for PC                      |
// |   illegal_op            ID opcode not recognised (combinational)         |
// +--------------------------------------------------------------------------+
// | Build option                                                             |
// |   PCU_FORWARDING_EN defined  : EX operand forwarding is enabled.         |
// |   PCU_FORWARDING_EN undefined: forwarding selects are tied to 00, and    |
// |                                ID stalls on any RAW against ID/EX or     |
// |                                EX/MEM until the producer is in MEM/WB.   |
// +--------------------------------------------------------------------------+
module pipe_ctrl_unit #(
   parameter int         REG_AW      = 5,
   parameter int         ALUOP_W     = 2,
   parameter logic [6:0] DOUBLEI_OPC = 7'b0101011
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         opcode_id,
   input  logic [REG_AW-1:0]  rs1_id,
   input  logic [REG_AW-1:0]  rs2_id,
   input  logic [REG_AW-1:0]  rd_id,
   input  logic               alu_zero_ex,
   output logic               ex_alu_src,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic [REG_AW-1:0]  ex_rs1,
   output logic [REG_AW-1:0]  ex_rs2,
   output logic               mem_read,
   output logic               mem_write,
   output logic [REG_AW-1:0]  mem_rd,
   output logic               wb_reg_write,
   output logic               wb_mem_to_reg,
   output logic [REG_AW-1:0]  wb_rd,
   output logic [1:0]         fwd_a,
   output logic [1:0]         fwd_b,
   output logic               pc_write,
   output logic               ifid_write,
   output logic               ifid_flush,
   output logic               branch_taken,
   output logic               illegal_op
);

   localparam logic [6:0] C_OPC_R    = 7'b0110011;
   localparam logic [6:0] C_OPC_IALU = 7'b0010011;
   localparam logic [6:0] C_OPC_LW   = 7'b0000011;
   localparam logic [6:0] C_OPC_SW   = 7'b0100011;
   localparam logic [6:0] C_OPC_BEQ  = 7'b1100011;

   typedef struct packed {
      logic               alu_src;
      logic               mem_to_reg;
      logic               reg_write;
      logic               mem_read;
      logic               mem_write;
      logic               branch;
      logic [ALUOP_W-1:0] alu_op;
      logic [REG_AW-1:0]  rs1;
      logic [REG_AW-1:0]  rs2;
      logic [REG_AW-1:0]  rd;
   } idex_t;

   typedef struct packed {
      logic              mem_to_reg;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic [REG_AW-1:0] rd;
   } exmem_t;

   typedef struct packed {
      logic              mem_to_reg;
      logic              reg_write;
      logic [REG_AW-1:0] rd;
   } memwb_t;

   idex_t  idex_d,  idex_q;
   exmem_t exmem_d, exmem_q;
   memwb_t memwb_d, memwb_q;

   idex_t  dec;
   logic   use_rs1;
   logic   use_rs2;
   logic   dec_illegal;
   logic   hz;
   logic   taken;

   // ID decode. An unrecognised opcode decodes to a full bubble, indices included.
   always_comb begin
      dec         = '0;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
      dec_illegal = 1'b0;
      case (opcode_id)
         C_OPC_R: begin
            dec.reg_write = 1'b1;
            dec.alu_op    = ALUOP_W'(2'b10);
            use_rs1       = 1'b1;
            use_rs2       = 1'b1;
         end
         C_OPC_IALU: begin
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_op    = ALUOP_W'(2'b10);
            use_rs1       = 1'b1;
         end
         C_OPC_LW: begin
            dec.alu_src    = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.reg_write  = 1'b1;
            dec.mem_read   = 1'b1;
            use_rs1        = 1'b1;
         end
         C_OPC_SW: begin
            dec.alu_src   = 1'b1;
            dec.mem_write = 1'b1;
            use_rs1       = 1'b1;
            use_rs2       = 1'b1;
         end
         C_OPC_BEQ: begin
            dec.branch = 1'b1;
            dec.alu_op = ALUOP_W'(2'b01);
            use_rs1    = 1'b1;
            use_rs2    = 1'b1;
         end
         DOUBLEI_OPC: begin
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_op    = ALUOP_W'(2'b11);
            use_rs1       = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
      if (!dec_illegal) begin
         dec.rs1 = rs1_id;
         dec.rs2 = rs2_id;
         dec.rd  = rd_id;
      end
   end

   // Hazard detection against the sources the ID instruction actually reads.
   always_comb begin
      logic idex_match;
      logic exmem_match;
      idex_match  = (idex_q.rd != '0) &&
                    ((use_rs1 && (idex_q.rd == rs1_id)) ||
                     (use_rs2 && (idex_q.rd == rs2_id)));
      exmem_match = (exmem_q.rd != '0) &&
                    ((use_rs1 && (exmem_q.rd == rs1_id)) ||
                     (use_rs2 && (exmem_q.rd == rs2_id)));
`ifdef PCU_FORWARDING_EN
      hz = idex_q.mem_read && idex_match;
`else
      // Without forwarding any in-flight producer blocks ID until it reaches
      // MEM/WB, where the register file bypass supplies the value.
      hz = (idex_q.reg_write && idex_match) ||
           (exmem_q.reg_write && exmem_match);
`endif
      taken = idex_q.branch && alu_zero_ex;
   end

   // Next-state: a taken branch or a stall replaces the ID instruction with a bubble.
   always_comb begin
      idex_d = (taken || hz) ? '0 : dec;

      exmem_d.mem_to_reg = idex_q.mem_to_reg;
      exmem_d.reg_write  = idex_q.reg_write;
      exmem_d.mem_read   = idex_q.mem_read;
      exmem_d.mem_write  = idex_q.mem_write;
      exmem_d.rd         = idex_q.rd;

      memwb_d.mem_to_reg = exmem_q.mem_to_reg;
      memwb_d.reg_write  = exmem_q.reg_write;
      memwb_d.rd         = exmem_q.rd;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
      end else begin
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
      end
   end

`ifdef PCU_FORWARDING_EN
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] src,
      input logic              em_rw,
      input logic [REG_AW-1:0] em_rd,
      input logic              mw_rw,
      input logic [REG_AW-1:0] mw_rd
   );
      // EX/MEM holds the younger result, so it is checked first.
      if (em_rw && (em_rd != '0) && (em_rd == src)) begin
         return 2'b10;
      end else if (mw_rw && (mw_rd != '0) && (mw_rd == src)) begin
         return 2'b01;
      end
      return 2'b00;
   endfunction
`endif

   // Outputs
   always_comb begin
      ex_alu_src    = idex_q.alu_src;
      ex_alu_op     = idex_q.alu_op;
      ex_rs1        = idex_q.rs1;
      ex_rs2        = idex_q.rs2;
      mem_read      = exmem_q.mem_read;
      mem_write     = exmem_q.mem_write;
      mem_rd        = exmem_q.rd;
      wb_reg_write  = memwb_q.reg_write;
      wb_mem_to_reg = memwb_q.mem_to_reg;
      wb_rd         = memwb_q.rd;
      illegal_op    = dec_illegal;

      pc_write     = !reset && (taken || !hz);
      ifid_write   = !reset && (taken || !hz);
      ifid_flush   = !reset && taken;
      branch_taken = !reset && taken;

      fwd_a = 2'b00;
      fwd_b = 2'b00;
`ifdef PCU_FORWARDING_EN
      if (!reset) begin
         fwd_a = fwd_sel(idex_q.rs1, exmem_q.reg_write, exmem_q.rd,
                         memwb_q.reg_write, memwb_q.rd);
         fwd_b = fwd_sel(idex_q.rs2, exmem_q.reg_write, exmem_q.rd,
                         memwb_q.reg_write, memwb_q.rd);
      end
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pipe_ctrl_unit                                          |
// | Description : Self-checking bench for pipe_ctrl_unit. Expectations       |
// |               follow the PCU_FORWARDING_EN build option.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pipe_ctrl_unit;

   localparam int REG_AW  = 5;
   localparam int ALUOP_W = 2;
`ifdef PCU_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   localparam logic [6:0] OPC_R    = 7'b0110011;
   localparam logic [6:0] OPC_I    = 7'b0010011;
   localparam logic [6:0] OPC_LW   = 7'b0000011;
   localparam logic [6:0] OPC_SW   = 7'b0100011;
   localparam logic [6:0] OPC_BEQ  = 7'b1100011;
   localparam logic [6:0] OPC_DBL  = 7'b0101011;
   localparam logic [6:0] OPC_NOP  = 7'b0000000;

   logic               clk;
   logic               reset;
   logic [6:0]         opcode_id;
   logic [REG_AW-1:0]  rs1_id, rs2_id, rd_id;
   logic               alu_zero_ex;
   logic               ex_alu_src;
   logic [ALUOP_W-1:0] ex_alu_op;
   logic [REG_AW-1:0]  ex_rs1, ex_rs2;
   logic               mem_read, mem_write;
   logic [REG_AW-1:0]  mem_rd;
   logic               wb_reg_write, wb_mem_to_reg;
   logic [REG_AW-1:0]  wb_rd;
   logic [1:0]         fwd_a, fwd_b;
   logic               pc_write, ifid_write, ifid_flush, branch_taken, illegal_op;

   pipe_ctrl_unit #(
      .REG_AW      (REG_AW),
      .ALUOP_W     (ALUOP_W),
      .DOUBLEI_OPC (OPC_DBL)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .opcode_id     (opcode_id),
      .rs1_id        (rs1_id),
      .rs2_id        (rs2_id),
      .rd_id         (rd_id),
      .alu_zero_ex   (alu_zero_ex),
      .ex_alu_src    (ex_alu_src),
      .ex_alu_op     (ex_alu_op),
      .ex_rs1        (ex_rs1),
      .ex_rs2        (ex_rs2),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_rd        (mem_rd),
      .wb_reg_write  (wb_reg_write),
      .wb_mem_to_reg (wb_mem_to_reg),
      .wb_rd         (wb_rd),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b),
      .pc_write      (pc_write),
      .ifid_write    (ifid_write),
      .ifid_flush    (ifid_flush),
      .branch_taken  (branch_taken),
      .illegal_op    (illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [6:0] op;
      logic [4:0] rd;
      logic       ill;
      logic       as;
      logic       m2r;
      logic       rw;
      logic       mr;
      logic       mw;
      logic [1:0] aop;
      logic [4:0] exp_rd;
   } vec_t;

   vec_t vecs[12];
   vec_t sbq[$];

   function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rd,
                               input logic ill, input logic as, input logic m2r,
                               input logic rw, input logic mr, input logic mw,
                               input logic [1:0] aop);
      vec_t v;
      v.op = op; v.rd = rd; v.ill = ill; v.as = as; v.m2r = m2r;
      v.rw = rw; v.mr = mr; v.mw = mw; v.aop = aop;
      v.exp_rd = ill ? 5'd0 : rd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] op, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd);
      opcode_id = op;
      rs1_id    = r1;
      rs2_id    = r2;
      rd_id     = rd;
   endtask

   // Counts consecutive cycles with pc_write low, holding the current ID word.
   task automatic count_stalls(output int n);
      n = 0;
      #1;
      while (pc_write === 1'b0 && n < 6) begin
         n++;
         chk("stall_ifid_write", ifid_write, 0);
         chk("stall_fwd_a", fwd_a, 0);
         step();
         #1;
      end
   endtask

   task automatic drain();
      drive(OPC_NOP, 0, 0, 0);
      repeat (3) step();
   endtask

   task automatic raw_seq(input int n_prod, input logic [4:0] r2);
      int n;
      for (int p = 0; p < n_prod; p++) begin
         drive(OPC_R, 0, 0, 5'd3);
         step();
      end
      drive(OPC_R, 5'd3, r2, 5'd4);
      count_stalls(n);
      chk("raw_stalls", n, FWD ? 0 : 2);
      step();
      drive(OPC_NOP, 0, 0, 0);
      #1;
      chk("raw_ex_rs1", ex_rs1, 3);
      chk("raw_fwd_a", fwd_a, FWD ? 2'b10 : 2'b00);
      chk("raw_fwd_b", fwd_b, (FWD && r2 == 5'd3) ? 2'b10 : 2'b00);
      drain();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      reset       = 1'b1;
      alu_zero_ex = 1'b0;
      drive(OPC_R, 0, 0, 5'd9);

      // Reset held two cycles.
      step();
      step();
      chk("rst_pc_write", pc_write, 0);
      chk("rst_ifid_write", ifid_write, 0);
      chk("rst_ifid_flush", ifid_flush, 0);
      chk("rst_branch_taken", branch_taken, 0);
      chk("rst_fwd_a", fwd_a, 0);
      chk("rst_fwd_b", fwd_b, 0);
      chk("rst_ex_alu_op", ex_alu_op, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_wb_reg_write", wb_reg_write, 0);
      reset = 1'b0;
      #1;
      chk("post_rst_pc_write", pc_write, 1);
      step();
      drive(OPC_NOP, 0, 0, 0);
      step();
      chk("rst_wb_early", wb_reg_write, 0);
      step();
      chk("rst_wb_reg_write3", wb_reg_write, 1);
      chk("rst_wb_rd3", wb_rd, 9);
      drain();

      // Decode table, flowing back-to-back through the pipe.
      vecs[0]  = mk(OPC_R,   5'd1,  0, 0, 0, 1, 0, 0, 2'b10);
      vecs[1]  = mk(OPC_I,   5'd2,  0, 1, 0, 1, 0, 0, 2'b10);
      vecs[2]  = mk(OPC_LW,  5'd3,  0, 1, 1, 1, 1, 0, 2'b00);
      vecs[3]  = mk(OPC_SW,  5'd4,  0, 1, 0, 0, 0, 1, 2'b00);
      vecs[4]  = mk(OPC_BEQ, 5'd5,  0, 0, 0, 0, 0, 0, 2'b01);
      vecs[5]  = mk(OPC_DBL, 5'd6,  0, 1, 0, 1, 0, 0, 2'b11);
      vecs[6]  = mk(7'h7F,   5'd7,  1, 0, 0, 0, 0, 0, 2'b00);
      vecs[7]  = mk(OPC_NOP, 5'd8,  1, 0, 0, 0, 0, 0, 2'b00);
      vecs[8]  = mk(OPC_LW,  5'd10, 0, 1, 1, 1, 1, 0, 2'b00);
      vecs[9]  = mk(OPC_R,   5'd11, 0, 0, 0, 1, 0, 0, 2'b10);
      vecs[10] = mk(OPC_NOP, 5'd0,  1, 0, 0, 0, 0, 0, 2'b00);
      vecs[11] = mk(OPC_NOP, 5'd0,  1, 0, 0, 0, 0, 0, 2'b00);
      repeat (3) sbq.push_front(mk(OPC_NOP, 5'd0, 1, 0, 0, 0, 0, 0, 2'b00));

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].op, 0, 0, vecs[i].rd);
         #1;
         chk("tbl_illegal_op", illegal_op, vecs[i].ill);
         chk("tbl_pc_write", pc_write, 1);
         sbq.push_front(vecs[i]);
         if (sbq.size() > 3) void'(sbq.pop_back());
         step();
         chk("tbl_ex_alu_src", ex_alu_src, sbq[0].as);
         chk("tbl_ex_alu_op", ex_alu_op, sbq[0].aop);
         chk("tbl_mem_read", mem_read, sbq[1].mr);
         chk("tbl_mem_write", mem_write, sbq[1].mw);
         chk("tbl_mem_rd", mem_rd, sbq[1].exp_rd);
         chk("tbl_wb_reg_write", wb_reg_write, sbq[2].rw);
         chk("tbl_wb_mem_to_reg", wb_mem_to_reg, sbq[2].m2r);
         chk("tbl_wb_rd", wb_rd, sbq[2].exp_rd);
         chk("tbl_branch_taken", branch_taken, 0);
      end
      drain();

      // Load-use: lw x5 then add x6,x5,x7.
      drive(OPC_LW, 0, 0, 5'd5);
      step();
      drive(OPC_R, 5'd5, 5'd7, 5'd6);
      count_stalls(n);
      chk("lu_stalls", n, FWD ? 1 : 2);
      chk("lu_bubble_alu_op", ex_alu_op, 0);
      chk("lu_bubble_rs1", ex_rs1, 0);
      step();
      drive(OPC_NOP, 0, 0, 0);
      #1;
      chk("lu_ex_alu_op", ex_alu_op, 2'b10);
      chk("lu_ex_rs1", ex_rs1, 5);
      chk("lu_fwd_a", fwd_a, FWD ? 2'b01 : 2'b00);
      chk("lu_fwd_b", fwd_b, 2'b00);
      drain();

      // RAW via EX/MEM, x0 as second source, and both stages matching.
      raw_seq(1, 5'd3);
      raw_seq(1, 5'd0);
      raw_seq(2, 5'd3);

      // Taken branch in EX while ID holds a consumer of an in-flight load.
      drive(OPC_LW, 0, 0, 5'd5);
      step();
      drive(OPC_BEQ, 0, 0, 0);
      step();
      drive(OPC_R, 5'd5, 5'd7, 5'd6);
      alu_zero_ex = 1'b1;
      #1;
      chk("br_branch_taken", branch_taken, 1);
      chk("br_ifid_flush", ifid_flush, 1);
      chk("br_pc_write", pc_write, 1);
      step();
      alu_zero_ex = 1'b0;
      drive(OPC_NOP, 0, 0, 0);
      #1;
      chk("br_bubble_alu_op", ex_alu_op, 0);
      chk("br_bubble_rs1", ex_rs1, 0);
      chk("br_flush_after", ifid_flush, 0);
      drain();

      // Reset arriving while a load-use stall is pending.
      drive(OPC_LW, 0, 0, 5'd5);
      step();
      drive(OPC_R, 5'd5, 5'd7, 5'd6);
      #1;
      chk("rs_stall_pc_write", pc_write, 0);
      reset = 1'b1;
      #1;
      chk("rs_ifid_write", ifid_write, 0);
      step();
      reset = 1'b0;
      drive(OPC_NOP, 0, 0, 0);
      #1;
      chk("rs_ex_alu_op", ex_alu_op, 0);
      chk("rs_mem_read", mem_read, 0);
      chk("rs_pc_write", pc_write, 1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
